hapara_icap_stream: RTL and testbench

//  Buffered, self-counting ICAP bitstream feeder for partial reconfiguration.
//  A BRAM-style slave port pre-fills or streams words into an internal FIFO;
//  a drain FSM pushes exactly LEN words to the ICAP port with per-byte bit reversal.

---
 rtl/hapara_icap_stream_pkg.sv | 25 ++
 rtl/hapara_burst_icap_bitswap.sv | 20 ++
 rtl/hapara_icap_stream_fifo.sv | 73 +++++++
 rtl/hapara_icap_stream.sv | 211 +++++++++++++++++++++
 tb/tb_hapara_icap_stream.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hapara_icap_stream_pkg.sv
// Shared definitions for the buffered ICAP bitstream feeder:
// slave register map (addr[3:2]), CTRL bit indices, STATUS bit positions
// and the drain FSM state encoding.
package hapara_icap_stream_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_LEN    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_ABORT = 1;

    localparam int unsigned STAT_OVF  = 31;
    localparam int unsigned STAT_DONE = 30;
    localparam int unsigned STAT_BUSY = 29;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2,
        FLUSH  = 2'd3
    } state_e;

endpackage

// File: rtl/hapara_burst_icap_bitswap.sv
// Per-byte bit reversal used to present bus words in ICAP bit order.
//  SWAP    1: byte_o[j] = byte_i[7-j]; 0: pass-through
//  byte_i  in  8  input byte
//  byte_o  out 8  output byte
module hapara_burst_icap_bitswap #(
    parameter bit SWAP = 1'b1
) (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    for (genvar j = 0; j < 8; j++) begin : g_bit
        if (SWAP) begin : g_swap
            assign byte_o[j] = byte_i[7-j];
        end else begin : g_pass
            assign byte_o[j] = byte_i[j];
        end
    end

endmodule

// File: rtl/hapara_icap_stream_fifo.sv
// Synchronous FIFO with single-cycle flush and an occupancy count.
//  clk_i    in   1          clock
//  rst_ni   in   1          synchronous active-low reset
//  push_i   in   1          write request (dropped when full unless popping)
//  pop_i    in   1          read request (ignored when empty)
//  flush_i  in   1          discard all contents
//  wdata_i  in   WIDTH      write data
//  rdata_o  out  WIDTH      head-of-queue data (combinational)
//  full_o   out  1          level == DEPTH
//  empty_o  out  1          level == 0
//  level_o  out  log2(D)+1  number of stored words, 0..DEPTH
module hapara_icap_stream_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    // a full FIFO still accepts a push in the same cycle as a pop
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                level_q <= level_q + LW'(1);
            end else if (pop_ok && !push_ok) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/hapara_icap_stream.sv
// Buffered, self-counting ICAP bitstream feeder. A BRAM-style slave port
// fills a FIFO; a drain FSM pushes exactly LEN words to the ICAP pins with
// optional per-byte bit reversal.
//  clk        in   1             clock
//  rst        in   1             synchronous active-low reset
//  en         in   1             slave access strobe
//  we         in   DATA_WIDTH/8  byte enables; write only when all set
//  addr       in   DATA_WIDTH    byte address, addr[3:2] selects register
//  din        in   DATA_WIDTH    write data
//  dout       out  DATA_WIDTH    read data, one cycle after the access
//  icap_csib  out  1             ICAP chip select, active low
//  icap_rdwrb out  1             ICAP direction, always write (0)
//  icap_i     out  DATA_WIDTH    ICAP data word
//  busy       out  1             run in progress
//  done       out  1             single-cycle pulse at run completion
module hapara_icap_stream
    import hapara_icap_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_WIDTH  = 24,
    parameter bit          BIT_SWAP   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [DATA_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    icap_csib,
    output logic                    icap_rdwrb,
    output logic [DATA_WIDTH-1:0]   icap_i,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   remaining_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   done_sticky_q;
    logic                   ovf_q;
    logic                   vld_q;
    logic [DATA_WIDTH-1:0]  word_q;
    logic                   csib_q;
    logic [DATA_WIDTH-1:0]  icap_q;
    logic [DATA_WIDTH-1:0]  dout_q;

    logic [1:0]             sel;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   start_req;
    logic                   abort_req;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [LW-1:0]          fifo_level;
    logic [DATA_WIDTH-1:0]  fifo_rdata;
    logic                   overflow;
    logic [DATA_WIDTH-1:0]  word_sw;
    logic [DATA_WIDTH-1:0]  rdata;
    logic                   unused_addr;

    assign unused_addr = ^{addr[DATA_WIDTH-1:4], addr[1:0]};

    assign sel       = addr[3:2];
    assign wr_acc    = en && (&we);
    assign rd_acc    = en && !(&we);
    assign start_req = wr_acc && (sel == REG_CTRL) && din[CTRL_START];
    assign abort_req = wr_acc && (sel == REG_CTRL) && din[CTRL_ABORT];

    assign fifo_push  = wr_acc && (sel == REG_DATA) && (state_q != FLUSH);
    // STREAM always has remaining != 0; an abort write blocks the pop so no
    // new word enters the output pipeline after the abort
    assign fifo_pop   = (state_q == STREAM) && !fifo_empty && !abort_req;
    assign fifo_flush = (state_q == FLUSH);
    assign overflow   = fifo_push && fifo_full && !fifo_pop;

    hapara_icap_stream_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (din),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    for (genvar k = 0; k < NB; k++) begin : g_swap
        hapara_burst_icap_bitswap #(
            .SWAP (BIT_SWAP)
        ) u_bitswap (
            .byte_i (word_q[8*k +: 8]),
            .byte_o (word_sw[8*k +: 8])
        );
    end

    always_comb begin
        rdata = '0;
        unique case (sel)
            REG_LEN: rdata[CNT_WIDTH-1:0] = len_q;
            REG_STATUS: begin
                rdata[STAT_OVF]  = ovf_q;
                rdata[STAT_DONE] = done_sticky_q;
                rdata[STAT_BUSY] = busy_q;
                rdata[LW-1:0]    = fifo_level;
            end
            default: rdata = '0;
        endcase
    end

    // Output path is two stages: pop captures the head word into word_q,
    // the following edge drives it (swapped) onto the ICAP pins. done is
    // registered off the DONE state so it lines up with the final word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            len_q         <= '0;
            remaining_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            done_sticky_q <= 1'b0;
            ovf_q         <= 1'b0;
            vld_q         <= 1'b0;
            word_q        <= '0;
            csib_q        <= 1'b1;
            icap_q        <= '0;
            dout_q        <= '0;
        end else begin
            vld_q <= fifo_pop;
            if (fifo_pop) begin
                word_q <= fifo_rdata;
            end
            csib_q <= !vld_q;
            if (vld_q) begin
                icap_q <= word_sw;
            end

            done_q <= (state_q == DONE) && !abort_req;

            if (wr_acc && (sel == REG_LEN) && !busy_q) begin
                len_q <= din[CNT_WIDTH-1:0];
            end
            if (rd_acc) begin
                dout_q <= rdata;
            end

            if (abort_req) begin
                state_q <= FLUSH;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_req) begin
                            busy_q <= 1'b1;
                            ovf_q  <= 1'b0;
                            if (len_q != '0) begin
                                state_q       <= STREAM;
                                remaining_q   <= len_q;
                                done_sticky_q <= 1'b0;
                            end else begin
                                state_q <= DONE;
                            end
                        end
                    end
                    STREAM: begin
                        if (fifo_pop) begin
                            remaining_q <= remaining_q - CNT_WIDTH'(1);
                            if (remaining_q == CNT_WIDTH'(1)) begin
                                state_q <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                        done_sticky_q <= 1'b1;
                    end
                    FLUSH: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end

            // placed after the FSM so a dropped push wins over a start clear
            if (overflow) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign dout       = dout_q;
    assign icap_csib  = csib_q;
    assign icap_rdwrb = 1'b0;
    assign icap_i     = icap_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_hapara_icap_stream.sv
module tb_hapara_icap_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        icap_csib;
    logic        icap_rdwrb;
    logic [31:0] icap_i;
    logic        busy;
    logic        done;

    hapara_icap_stream #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (16),
        .CNT_WIDTH  (24),
        .BIT_SWAP   (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .dout       (dout),
        .icap_csib  (icap_csib),
        .icap_rdwrb (icap_rdwrb),
        .icap_i     (icap_i),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    // observed ICAP traffic
    logic [31:0] got_w[$];
    int unsigned got_c[$];
    int          done_cnt = 0;
    int unsigned done_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst === 1'b1) begin
            if (icap_csib === 1'b0) begin
                got_w.push_back(icap_i);
                got_c.push_back(cyc);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    // reference: bit j of byte k comes from bit 7-j of the same byte
    function automatic logic [31:0] swap_ref(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; we = 4'hF; addr = a; din = d;
        tick();
        en = 1'b0; we = 4'h0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] r);
        en = 1'b1; we = 4'h0; addr = a;
        tick();
        en = 1'b0;
        r = dout;
    endtask

    task automatic mon_clear();
        got_w.delete();
        got_c.delete();
        done_cnt = 0;
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (busy === 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] r;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] exp_w[$];
    logic [31:0] mq[$];
    logic [31:0] t1_data[3];
    int unsigned scyc;
    int unsigned wcyc[4];
    int          n;
    int          len;
    int          extra;
    int          npush;
    int          npre;

    initial begin
        rst = 1'b0; en = 1'b0; we = 4'h0; addr = '0; din = '0;
        t1_data[0] = 32'h0000_0001;
        t1_data[1] = 32'h0000_0080;
        t1_data[2] = 32'hAA99_5566;

        // ---- reset state
        repeat (2) tick();
        check("rst_csib",  {31'd0, icap_csib}, 32'd1);
        check("rst_icap",  icap_i, 32'd0);
        check("rst_rdwrb", {31'd0, icap_rdwrb}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_dout",  dout, 32'd0);
        rst = 1'b1;
        tick();
        bus_rd(32'hC, r);  check("rst_status", r, 32'd0);
        bus_rd(32'h8, r);  check("rst_len", r, 32'd0);
        bus_wr(32'h8, 32'hFFFF_FFFF);
        bus_rd(32'h8, r);  check("len_zext", r, 32'h00FF_FFFF);
        en = 1'b1; we = 4'h7; addr = 32'h8; din = 32'h5;
        tick();
        en = 1'b0; we = 4'h0;
        bus_rd(32'h8, r);  check("len_partial_wr", r, 32'h00FF_FFFF);

        // ---- 1: prefilled run of 3 words
        bus_wr(32'h8, 32'd3);
        exp_w.delete();
        for (int k = 0; k < 3; k++) begin
            bus_wr(32'h0, t1_data[k]);
            exp_w.push_back(swap_ref(t1_data[k]));
        end
        bus_rd(32'hC, r);  check("t1_level", r, 32'd3);
        mon_clear();
        bus_wr(32'h4, 32'h1);
        scyc = cyc;
        wait_idle(30, "t1_idle");
        tick(); tick();
        check("t1_count", got_w.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got_w.size()) begin
                check($sformatf("t1_word%0d", k), got_w[k], exp_w[k]);
                check($sformatf("t1_cyc%0d", k), got_c[k], scyc + 2 + k);
            end
        end
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_done_cyc", done_cyc, scyc + 4);
        bus_rd(32'hC, r);  check("t1_status", r, 32'h4000_0000);

        // ---- 2: LEN == 0
        bus_wr(32'h8, 32'd0);
        mon_clear();
        bus_wr(32'h4, 32'h1);
        check("t2_busy",  {31'd0, busy}, 32'd1);
        check("t2_done0", {31'd0, done}, 32'd0);
        tick();
        check("t2_done1", {31'd0, done}, 32'd1);
        check("t2_busy_off", {31'd0, busy}, 32'd0);
        tick();
        check("t2_done2", {31'd0, done}, 32'd0);
        check("t2_nowords", got_w.size(), 32'd0);
        bus_rd(32'hC, r);  check("t2_status", r, 32'h4000_0000);

        // ---- 3: trickle-fed run, one word every third cycle
        bus_wr(32'h8, 32'd4);
        mon_clear();
        exp_w.delete();
        bus_wr(32'h4, 32'h1);
        tick();
        for (int k = 0; k < 4; k++) begin
            d = $urandom;
            bus_wr(32'h0, d);
            wcyc[k] = cyc;
            exp_w.push_back(swap_ref(d));
            tick(); tick();
        end
        wait_idle(20, "t3_idle");
        tick();
        check("t3_count", got_w.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_w.size()) begin
                check($sformatf("t3_word%0d", k), got_w[k], exp_w[k]);
                check($sformatf("t3_lat%0d", k), got_c[k], wcyc[k] + 2);
            end
        end
        check("t3_done_cnt", done_cnt, 32'd1);
        check("t3_done_cyc", done_cyc, wcyc[3] + 2);

        // ---- 4: overflow on the 17th pre-fill word
        rst = 1'b0; tick(); rst = 1'b1;
        exp_w.delete();
        for (int k = 0; k < 17; k++) begin
            d = $urandom;
            bus_wr(32'h0, d);
            if (k < 16) exp_w.push_back(swap_ref(d));
        end
        bus_rd(32'hC, r);  check("t4_ovf_status", r, 32'h8000_0010);
        bus_wr(32'h8, 32'd16);
        mon_clear();
        bus_wr(32'h4, 32'h1);
        bus_rd(32'hC, r);  check("t4_ovf_clear", r & 32'hE000_0000, 32'h2000_0000);
        wait_idle(40, "t4_idle");
        tick(); tick();
        check("t4_count", got_w.size(), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < got_w.size()) check($sformatf("t4_word%0d", k), got_w[k], exp_w[k]);
        end
        bus_rd(32'hC, r);  check("t4_status_end", r, 32'h4000_0000);

        // ---- 5: abort mid-stream; LEN write while busy ignored
        bus_wr(32'h8, 32'd8);
        for (int k = 0; k < 2; k++) bus_wr(32'h0, $urandom);
        mon_clear();
        bus_wr(32'h4, 32'h1);
        bus_wr(32'h8, 32'd5);
        bus_rd(32'h8, r);  check("t5_len_locked", r, 32'd8);
        n = 0;
        while (got_w.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        check("t5_two_words", got_w.size(), 32'd2);
        tick();
        bus_wr(32'h4, 32'h2);
        tick();
        check("t5_busy", {31'd0, busy}, 32'd0);
        repeat (4) tick();
        bus_rd(32'hC, r);  check("t5_status", r, 32'd0);
        check("t5_no_done", done_cnt, 32'd0);
        for (int k = 0; k < 3; k++) bus_wr(32'h0, $urandom);
        bus_rd(32'hC, r);  check("t5_prefill", r, 32'd3);
        bus_wr(32'h4, 32'h3);
        tick();
        check("t5_abort_wins", {31'd0, busy}, 32'd0);
        bus_rd(32'hC, r);  check("t5_flushed", r, 32'd0);
        check("t5_no_extra", got_w.size(), 32'd2);

        // ---- 6: reset during a run
        bus_wr(32'h8, 32'd8);
        for (int k = 0; k < 5; k++) bus_wr(32'h0, $urandom);
        bus_wr(32'h4, 32'h1);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("t6_csib", {31'd0, icap_csib}, 32'd1);
        check("t6_icap", icap_i, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_dout", dout, 32'd0);
        rst = 1'b1;
        bus_rd(32'hC, r);  check("t6_status", r, 32'd0);
        bus_rd(32'h8, r);  check("t6_len", r, 32'd0);

        // ---- random runs against a FIFO-queue model
        mq.delete();
        for (int it = 0; it < 6; it++) begin
            len   = int'($urandom_range(1, 10));
            extra = (mq.size() <= 2) ? int'($urandom_range(0, 2)) : 0;
            npush = len + extra;
            npre  = int'($urandom_range(0, npush));
            bus_wr(32'h8, len);
            for (int k = 0; k < npre; k++) begin
                d = $urandom;
                bus_wr(32'h0, d);
                mq.push_back(d);
            end
            mon_clear();
            bus_wr(32'h4, 32'h1);
            for (int k = npre; k < npush; k++) begin
                repeat ($urandom_range(0, 3)) tick();
                d = $urandom;
                bus_wr(32'h0, d);
                mq.push_back(d);
            end
            wait_idle(100, $sformatf("rnd%0d_idle", it));
            tick(); tick();
            check($sformatf("rnd%0d_count", it), got_w.size(), len);
            for (int k = 0; k < len; k++) begin
                e = swap_ref(mq.pop_front());
                if (k < got_w.size()) check($sformatf("rnd%0d_word%0d", it, k), got_w[k], e);
            end
            check($sformatf("rnd%0d_done", it), done_cnt, 32'd1);
            bus_rd(32'hC, r);
            check($sformatf("rnd%0d_status", it), r, 32'h4000_0000 | mq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
